// File: rtl/sprite_move_engine_if.sv
`default_nettype none
// ============================================================================
// Module      : sprite_move_engine_if
// Description : Framebuffer write-port bundle (address / data / strobe)
//               between the sprite mover and the frame driver.
// Revision    : 1.0 - initial release
// ============================================================================
interface sprite_move_engine_if #(
  parameter int ADDR_W  = 15,
  parameter int COLOR_W = 24
) ();

  logic [ADDR_W-1:0]  wr_addr;
  logic [COLOR_W-1:0] wr_data;
  logic               wr_en;

  // Pixel producer side
  modport master (
    output wr_addr,
    output wr_data,
    output wr_en
  );

  // Framebuffer side
  modport slave (
    input  wr_addr,
    input  wr_data,
    input  wr_en
  );

endinterface
`default_nettype wire

// File: rtl/sprite_move_engine.sv
`default_nettype none
// ============================================================================
// Module      : sprite_move_engine
// Description : Moves a solid SPRITE_W x SPRITE_H rectangle around a
//               FB_WIDTH x FB_HEIGHT framebuffer. After reset the whole
//               framebuffer is cleared and the sprite drawn at (0,0). Each
//               accepted move erases the old rectangle, updates the position,
//               draws the new rectangle and then holds for FRAMES_PER_MOVE
//               frame ticks. One pixel is written per wr_en cycle.
// Options     : `define SPRITE_WRAP_EN makes the position and the rectangle
//               pixels wrap around the framebuffer edges (toroidal); when
//               undefined the position is clamped so the sprite stays inside.
// Revision    : 1.0 - initial release
// ============================================================================
module sprite_move_engine #(
  parameter int FB_WIDTH        = 160,
  parameter int FB_HEIGHT       = 120,
  parameter int ADDR_W          = 15,
  parameter int COLOR_W         = 24,
  parameter int SPRITE_W        = 4,
  parameter int SPRITE_H        = 4,
  parameter int STEP            = 1,
  parameter int FRAMES_PER_MOVE = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 frame_tick,
  input  logic                 move_right,
  input  logic                 move_left,
  input  logic                 move_up,
  input  logic                 move_down,
  input  logic [COLOR_W-1:0]   fg_color,
  input  logic [COLOR_W-1:0]   bg_color,
  sprite_move_engine_if.master wr,
  output logic                 busy,
  output logic [9:0]           pos_x,
  output logic [9:0]           pos_y
);

  // --------------------------------------------------------------------------
  // State encoding
  // --------------------------------------------------------------------------
  localparam logic [2:0] c_ST_CLEAR_ALL = 3'd0;
  localparam logic [2:0] c_ST_WAIT      = 3'd1;
  localparam logic [2:0] c_ST_ERASE     = 3'd2;
  localparam logic [2:0] c_ST_UPDATE    = 3'd3;
  localparam logic [2:0] c_ST_DRAW      = 3'd4;
  localparam logic [2:0] c_ST_HOLD      = 3'd5;

  // --------------------------------------------------------------------------
  // Derived constants
  // --------------------------------------------------------------------------
  localparam int                c_FB_PIXELS = FB_WIDTH * FB_HEIGHT;
  localparam logic [ADDR_W-1:0] c_LAST_ADDR = ADDR_W'(c_FB_PIXELS - 1);
  localparam logic [9:0]        c_SW_LAST   = 10'(SPRITE_W - 1);
  localparam logic [9:0]        c_SH_LAST   = 10'(SPRITE_H - 1);
  localparam logic signed [11:0] c_STEP     = 12'(STEP);
  localparam logic [15:0]       c_FRAMES    = 16'(FRAMES_PER_MOVE);
`ifdef SPRITE_WRAP_EN
  localparam logic signed [11:0] c_FB_W_S   = 12'(FB_WIDTH);
  localparam logic signed [11:0] c_FB_H_S   = 12'(FB_HEIGHT);
  localparam logic [10:0]        c_FB_W_U   = 11'(FB_WIDTH);
  localparam logic [10:0]        c_FB_H_U   = 11'(FB_HEIGHT);
`else
  localparam logic signed [11:0] c_MAX_X    = 12'(FB_WIDTH - SPRITE_W);
  localparam logic signed [11:0] c_MAX_Y    = 12'(FB_HEIGHT - SPRITE_H);
`endif

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  logic [2:0]          r_state;
  logic [ADDR_W-1:0]   r_clr_addr;   // CLEAR_ALL sweep address
  logic [9:0]          r_ox;         // column offset inside the rectangle
  logic [9:0]          r_oy;         // row offset inside the rectangle
  logic signed [11:0]  r_dx;         // displacement latched in WAIT
  logic signed [11:0]  r_dy;
  logic [9:0]          r_pos_x;
  logic [9:0]          r_pos_y;
  logic [15:0]         r_frames;     // frame ticks seen in HOLD
  logic                r_wr_en;
  logic [ADDR_W-1:0]   r_wr_addr;
  logic [COLOR_W-1:0]  r_wr_data;
  logic                r_busy;

  // --------------------------------------------------------------------------
  // Combinational signals
  // --------------------------------------------------------------------------
  logic [2:0]          w_state_nxt;
  logic signed [11:0]  w_dx;
  logic signed [11:0]  w_dy;
  logic                w_move;
  logic signed [11:0]  w_sum_x;
  logic signed [11:0]  w_sum_y;
  logic [9:0]          w_new_x;
  logic [9:0]          w_new_y;
  logic [9:0]          w_px;
  logic [9:0]          w_py;
  logic [ADDR_W-1:0]   w_pix_addr;
  logic                w_rect_last;
  logic                w_clr_last;
  logic [15:0]         w_frames_inc;
  logic                w_hold_done;
  logic                w_wr_en_nxt;
  logic [ADDR_W-1:0]   w_wr_addr_nxt;
  logic [COLOR_W-1:0]  w_wr_data_nxt;
  logic                w_busy_nxt;

  // Decode the direction levels into a signed displacement; opposing pairs cancel
  always_comb begin
    w_dx = '0;
    w_dy = '0;
    if (move_right && !move_left) begin
      w_dx = c_STEP;
    end else if (move_left && !move_right) begin
      w_dx = -c_STEP;
    end
    if (move_down && !move_up) begin
      w_dy = c_STEP;
    end else if (move_up && !move_down) begin
      w_dy = -c_STEP;
    end
  end

  assign w_move = (w_dx != '0) || (w_dy != '0);

  // Candidate position before edge handling
  assign w_sum_x = $signed({2'b00, r_pos_x}) + r_dx;
  assign w_sum_y = $signed({2'b00, r_pos_y}) + r_dy;

  // Edge handling for the new position: wrap or clamp
  always_comb begin
    w_new_x = r_pos_x;
    w_new_y = r_pos_y;
`ifdef SPRITE_WRAP_EN
    if (w_sum_x < 12'sd0) begin
      w_new_x = 10'(w_sum_x + c_FB_W_S);
    end else if (w_sum_x >= c_FB_W_S) begin
      w_new_x = 10'(w_sum_x - c_FB_W_S);
    end else begin
      w_new_x = w_sum_x[9:0];
    end
    if (w_sum_y < 12'sd0) begin
      w_new_y = 10'(w_sum_y + c_FB_H_S);
    end else if (w_sum_y >= c_FB_H_S) begin
      w_new_y = 10'(w_sum_y - c_FB_H_S);
    end else begin
      w_new_y = w_sum_y[9:0];
    end
`else
    if (w_sum_x < 12'sd0) begin
      w_new_x = '0;
    end else if (w_sum_x > c_MAX_X) begin
      w_new_x = 10'(c_MAX_X);
    end else begin
      w_new_x = w_sum_x[9:0];
    end
    if (w_sum_y < 12'sd0) begin
      w_new_y = '0;
    end else if (w_sum_y > c_MAX_Y) begin
      w_new_y = 10'(c_MAX_Y);
    end else begin
      w_new_y = w_sum_y[9:0];
    end
`endif
  end

  // Coordinates of the rectangle pixel currently being written
`ifdef SPRITE_WRAP_EN
  logic [10:0] w_px_sum;
  logic [10:0] w_py_sum;
  assign w_px_sum = {1'b0, r_pos_x} + {1'b0, r_ox};
  assign w_py_sum = {1'b0, r_pos_y} + {1'b0, r_oy};
  assign w_px = (w_px_sum >= c_FB_W_U) ? 10'(w_px_sum - c_FB_W_U) : w_px_sum[9:0];
  assign w_py = (w_py_sum >= c_FB_H_U) ? 10'(w_py_sum - c_FB_H_U) : w_py_sum[9:0];
`else
  // Clamped positions guarantee the rectangle never leaves the framebuffer
  assign w_px = r_pos_x + r_ox;
  assign w_py = r_pos_y + r_oy;
`endif

  assign w_pix_addr   = ADDR_W'(32'(w_py) * 32'(FB_WIDTH) + 32'(w_px));
  assign w_rect_last  = (r_ox == c_SW_LAST) && (r_oy == c_SH_LAST);
  assign w_clr_last   = (r_clr_addr == c_LAST_ADDR);
  assign w_frames_inc = r_frames + {15'd0, frame_tick};
  assign w_hold_done  = (w_frames_inc >= c_FRAMES);

  // State register; reset parks in CLEAR_ALL so the sweep starts on the first edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= c_ST_CLEAR_ALL;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_ST_CLEAR_ALL: if (w_clr_last)  w_state_nxt = c_ST_DRAW;
      c_ST_WAIT:      if (w_move)      w_state_nxt = c_ST_ERASE;
      c_ST_ERASE:     if (w_rect_last) w_state_nxt = c_ST_UPDATE;
      c_ST_UPDATE:                     w_state_nxt = c_ST_DRAW;
      c_ST_DRAW:      if (w_rect_last) w_state_nxt = c_ST_HOLD;
      c_ST_HOLD:      if (w_hold_done) w_state_nxt = c_ST_WAIT;
      default:                         w_state_nxt = c_ST_CLEAR_ALL;
    endcase
  end

  // Output decode; address and data hold their last value while not writing
  always_comb begin
    w_wr_en_nxt   = 1'b0;
    w_wr_addr_nxt = r_wr_addr;
    w_wr_data_nxt = r_wr_data;
    w_busy_nxt    = 1'b1;
    case (r_state)
      c_ST_CLEAR_ALL: begin
        w_wr_en_nxt   = 1'b1;
        w_wr_addr_nxt = r_clr_addr;
        w_wr_data_nxt = bg_color;
      end
      c_ST_WAIT: begin
        w_busy_nxt    = 1'b0;
      end
      c_ST_ERASE: begin
        w_wr_en_nxt   = 1'b1;
        w_wr_addr_nxt = w_pix_addr;
        w_wr_data_nxt = bg_color;
      end
      c_ST_DRAW: begin
        w_wr_en_nxt   = 1'b1;
        w_wr_addr_nxt = w_pix_addr;
        w_wr_data_nxt = fg_color;
      end
      default: begin
        w_wr_en_nxt   = 1'b0;
      end
    endcase
  end

  // Register the write port and busy so they leave the block glitch-free and aligned
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_en   <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
      r_busy    <= 1'b0;
    end else begin
      r_wr_en   <= w_wr_en_nxt;
      r_wr_addr <= w_wr_addr_nxt;
      r_wr_data <= w_wr_data_nxt;
      r_busy    <= w_busy_nxt;
    end
  end

  // Sweep counter, rectangle scan, latched displacement and position
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_clr_addr <= '0;
      r_ox       <= '0;
      r_oy       <= '0;
      r_dx       <= '0;
      r_dy       <= '0;
      r_pos_x    <= '0;
      r_pos_y    <= '0;
    end else begin
      case (r_state)
        c_ST_CLEAR_ALL: begin
          r_clr_addr <= w_clr_last ? '0 : r_clr_addr + ADDR_W'(1);
        end
        c_ST_WAIT: begin
          if (w_move) begin
            r_dx <= w_dx;
            r_dy <= w_dy;
          end
        end
        c_ST_ERASE, c_ST_DRAW: begin
          // Row-major scan, x inner; wraps back to (0,0) after the last pixel
          if (r_ox == c_SW_LAST) begin
            r_ox <= '0;
            r_oy <= (r_oy == c_SH_LAST) ? '0 : r_oy + 10'd1;
          end else begin
            r_ox <= r_ox + 10'd1;
          end
        end
        c_ST_UPDATE: begin
          r_pos_x <= w_new_x;
          r_pos_y <= w_new_y;
        end
        default: begin
          r_clr_addr <= r_clr_addr;
        end
      endcase
    end
  end

  // Frame-tick counter: only runs in HOLD, a tick on the entry cycle counts
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_frames <= '0;
    end else if (r_state == c_ST_HOLD) begin
      r_frames <= w_frames_inc;
    end else begin
      r_frames <= '0;
    end
  end

  assign wr.wr_en   = r_wr_en;
  assign wr.wr_addr = r_wr_addr;
  assign wr.wr_data = r_wr_data;
  assign busy       = r_busy;
  assign pos_x      = r_pos_x;
  assign pos_y      = r_pos_y;

endmodule
`default_nettype wire

// File: tb/tb_sprite_move_engine.sv
`default_nettype none
// ============================================================================
// Module      : tb_sprite_move_engine
// Description : Scoreboard bench for sprite_move_engine. The stimulus side
//               pushes the expected pixel writes of each operation into a
//               queue; an independent monitor pops and compares every write.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sprite_move_engine;

  localparam int FBW  = 160;
  localparam int FBH  = 120;
  localparam int AW   = 15;
  localparam int CW   = 24;
  localparam int SW   = 4;
  localparam int SH   = 4;
  localparam int STEP = 1;
  localparam int FPM  = 2;

  logic          clk        = 1'b0;
  logic          rst        = 1'b1;
  logic          frame_tick = 1'b0;
  logic          mr = 1'b0, ml = 1'b0, mu = 1'b0, md = 1'b0;
  logic [CW-1:0] fg = '0;
  logic [CW-1:0] bg = '0;
  logic          busy;
  logic [9:0]    pos_x;
  logic [9:0]    pos_y;

  sprite_move_engine_if #(.ADDR_W(AW), .COLOR_W(CW)) wr_bus ();

  sprite_move_engine #(
    .FB_WIDTH(FBW), .FB_HEIGHT(FBH), .ADDR_W(AW), .COLOR_W(CW),
    .SPRITE_W(SW), .SPRITE_H(SH), .STEP(STEP), .FRAMES_PER_MOVE(FPM)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .frame_tick (frame_tick),
    .move_right (mr),
    .move_left  (ml),
    .move_up    (mu),
    .move_down  (md),
    .fg_color   (fg),
    .bg_color   (bg),
    .wr         (wr_bus),
    .busy       (busy),
    .pos_x      (pos_x),
    .pos_y      (pos_y)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [CW-1:0] data;
  } wr_t;

  wr_t exp_q[$];
  int  checks   = 0;
  int  failures = 0;
  int  mx = 0;
  int  my = 0;

  // Free-running one-cycle frame tick with irregular spacing
  initial begin
    forever begin
      repeat ($urandom_range(3, 12)) @(negedge clk);
      frame_tick = 1'b1;
      @(negedge clk);
      frame_tick = 1'b0;
    end
  end

  // Monitor: every write must be in range and match the head of the queue
  always @(negedge clk) begin
    wr_t got;
    wr_t want;
    if (!rst && wr_bus.wr_en === 1'b1) begin
      got.addr = wr_bus.wr_addr;
      got.data = wr_bus.wr_data;
      checks++;
      if (int'(got.addr) >= FBW * FBH) begin
        failures++;
        $display("FAIL addr_range got=%0d limit=%0d", got.addr, FBW * FBH);
      end
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_write got addr=%0d data=%h required no write", got.addr, got.data);
      end else begin
        want = exp_q.pop_front();
        if (got !== want) begin
          failures++;
          $display("FAIL write got addr=%0d data=%h required addr=%0d data=%h",
                   got.addr, got.data, want.addr, want.data);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] req);
    checks++;
    if (got !== req) begin
      failures++;
      $display("FAIL %s got=%0d required=%0d", name, got, req);
    end
  endtask

  task automatic check_pos(input string tag);
    checks++;
    if (pos_x !== 10'(mx) || pos_y !== 10'(my)) begin
      failures++;
      $display("FAIL %s_pos got=(%0d,%0d) required=(%0d,%0d)", tag, pos_x, pos_y, mx, my);
    end
  endtask

  // Reference model: the rectangle at (x,y) written row by row, x inner
  task automatic push_rect(input int x, input int y, input logic [CW-1:0] col);
    for (int r = 0; r < SH; r++) begin
      for (int c = 0; c < SW; c++) begin
        int  px;
        int  py;
        wr_t e;
`ifdef SPRITE_WRAP_EN
        px = (x + c) % FBW;
        py = (y + r) % FBH;
`else
        px = x + c;
        py = y + r;
`endif
        e.addr = AW'(py * FBW + px);
        e.data = col;
        exp_q.push_back(e);
      end
    end
  endtask

  // Reference model of one move request seen in WAIT
  task automatic model_move(input bit r, input bit l, input bit u, input bit d, output bit moved);
    int dx;
    int dy;
    int nx;
    int ny;
    dx = (r && !l) ? STEP : ((l && !r) ? -STEP : 0);
    dy = (d && !u) ? STEP : ((u && !d) ? -STEP : 0);
    moved = (dx != 0) || (dy != 0);
    if (moved) begin
      push_rect(mx, my, bg);
      nx = mx + dx;
      ny = my + dy;
`ifdef SPRITE_WRAP_EN
      nx = ((nx % FBW) + FBW) % FBW;
      ny = ((ny % FBH) + FBH) % FBH;
`else
      nx = (nx < 0) ? 0 : ((nx > FBW - SW) ? FBW - SW : nx);
      ny = (ny < 0) ? 0 : ((ny > FBH - SH) ? FBH - SH : ny);
`endif
      mx = nx;
      my = ny;
      push_rect(mx, my, fg);
    end
  endtask

  // Queue the full clear plus the initial sprite, then release reset
  task automatic do_init();
    wr_t e;
    mx = 0;
    my = 0;
    for (int a = 0; a < FBW * FBH; a++) begin
      e.addr = AW'(a);
      e.data = bg;
      exp_q.push_back(e);
    end
    push_rect(0, 0, fg);
    @(negedge clk);
    #2 rst = 1'b0;
  endtask

  task automatic wait_empty(input int bound, input string tag);
    int n = 0;
    while (exp_q.size() != 0 && n < bound) begin
      @(negedge clk);
      #1;
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL %s_timeout pending=%0d required=0", tag, exp_q.size());
      exp_q.delete();
    end
  endtask

  // Wait for busy to fall; the HOLD period must span exactly FPM ticks
  task automatic wait_idle(input int bound, input bit check_ticks, input string tag);
    int n     = 0;
    int ticks = 0;
    bit idle  = 1'b0;
    while (!idle && n < bound) begin
      @(posedge clk);
      if (frame_tick) ticks++;
      #1;
      n++;
      idle = (busy === 1'b0);
    end
    checks++;
    if (!idle) begin
      failures++;
      $display("FAIL %s_busy_timeout got busy=%b required=0", tag, busy);
    end else if (check_ticks) begin
      checks++;
      if (ticks != FPM) begin
        failures++;
        $display("FAIL %s_hold_ticks got=%0d required=%0d", tag, ticks, FPM);
      end
    end
  endtask

  task automatic pulse(input bit r, input bit l, input bit u, input bit d);
    @(negedge clk);
    mr = r; ml = l; mu = u; md = d;
    @(negedge clk);
    mr = 1'b0; ml = 1'b0; mu = 1'b0; md = 1'b0;
  endtask

  task automatic move_and_check(input bit r, input bit l, input bit u, input bit d, input string tag);
    bit moved;
    bg = CW'($urandom);
    fg = CW'($urandom);
    model_move(r, l, u, d, moved);
    pulse(r, l, u, d);
    if (moved) begin
      wait_empty(300, tag);
      wait_idle(400, 1'b1, tag);
    end else begin
      repeat (8) @(negedge clk);
      #1;
      chk({tag, "_noop_busy"}, 32'(busy), 32'd0);
    end
    check_pos(tag);
  endtask

  initial begin
    bit       moved;
    bit [3:0] dirs;
    int       n;

    // Reset values while reset is held
    repeat (3) @(posedge clk);
    #1;
    chk("rst_wr_en",   32'(wr_bus.wr_en),   32'd0);
    chk("rst_wr_addr", 32'(wr_bus.wr_addr), 32'd0);
    chk("rst_wr_data", 32'(wr_bus.wr_data), 32'd0);
    chk("rst_busy",    32'(busy),           32'd0);
    chk("rst_pos_x",   32'(pos_x),          32'd0);
    chk("rst_pos_y",   32'(pos_y),          32'd0);

    // Full clear followed by the sprite at the origin
    bg = CW'($urandom);
    fg = CW'($urandom);
    do_init();
    wait_empty(25000, "init");
    wait_idle(400, 1'b1, "init");
    check_pos("init");

    // Directed single step right from the origin
    move_and_check(1'b1, 1'b0, 1'b0, 1'b0, "right");

    // Random walk near the origin exercises the low clamps and cancelling pairs
    for (int i = 0; i < 30; i++) begin
      dirs = 4'($urandom_range(0, 15));
      move_and_check(dirs[0], dirs[1], dirs[2], dirs[3], "rand");
    end

    // Reset in the middle of a draw, then a complete re-initialisation
    bg = CW'($urandom);
    fg = CW'($urandom);
    model_move(1'b0, 1'b0, 1'b0, 1'b1, moved);
    pulse(1'b0, 1'b0, 1'b0, 1'b1);
    n = 0;
    while (exp_q.size() > 8 && n < 300) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("mid_draw_reached", 32'(exp_q.size() <= 8), 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("abort_wr_en",   32'(wr_bus.wr_en),   32'd0);
    chk("abort_wr_addr", 32'(wr_bus.wr_addr), 32'd0);
    chk("abort_wr_data", 32'(wr_bus.wr_data), 32'd0);
    chk("abort_busy",    32'(busy),           32'd0);
    chk("abort_pos_x",   32'(pos_x),          32'd0);
    chk("abort_pos_y",   32'(pos_y),          32'd0);
    exp_q.delete();
    repeat (3) @(posedge clk);
    bg = CW'($urandom);
    fg = CW'($urandom);
    do_init();
    wait_empty(25000, "reinit");
    wait_idle(400, 1'b1, "reinit");
    check_pos("reinit");

    // Hold right+down: repeated moves run into the bottom-right clamp
    for (int k = 0; k < FBW + 4; k++) begin
      bg = CW'($urandom);
      fg = CW'($urandom);
      model_move(1'b1, 1'b0, 1'b0, 1'b1, moved);
      if (k == 0) begin
        @(negedge clk);
        mr = 1'b1;
        md = 1'b1;
      end
      wait_empty(400, "held");
      check_pos("held");
    end
    mr = 1'b0;
    md = 1'b0;
    wait_idle(400, 1'b1, "held_end");
    check_pos("held_end");

    // Opposing pairs alone never start a move
    @(negedge clk);
    mr = 1'b1;
    ml = 1'b1;
    repeat (40) @(negedge clk);
    #1;
    chk("lr_busy", 32'(busy), 32'd0);
    check_pos("lr");
    mr = 1'b0;
    ml = 1'b0;
    @(negedge clk);
    mu = 1'b1;
    md = 1'b1;
    repeat (40) @(negedge clk);
    #1;
    chk("ud_busy", 32'(busy), 32'd0);
    check_pos("ud");
    mu = 1'b0;
    md = 1'b0;

    // Step back away from the corner
    move_and_check(1'b0, 1'b1, 1'b1, 1'b0, "leave_corner");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sprite_move_engine.md
Name: sprite_move_engine

Overview:
- Moves a solid rectangular sprite around a reduced-resolution framebuffer, one framebuffer pixel per write cycle.
- Driven by four debounced direction inputs. Issues address/data/write-enable to the vga_frame_driver write port.
- Per move: erases the old rectangle, updates the position, draws the new rectangle, then holds for a programmable number of frames.
- Successor to the single-pixel mover: adds parametrised sprite size, step, frame geometry, diagonal moves and edge clamping.

Parameters:
- FB_WIDTH, 160, framebuffer width in virtual pixels
- FB_HEIGHT, 120, framebuffer height in virtual pixels
- ADDR_W, 15, write address width; must satisfy 2^ADDR_W >= FB_WIDTH*FB_HEIGHT
- COLOR_W, 24, pixel data width
- SPRITE_W, 4, sprite width in virtual pixels (1..FB_WIDTH)
- SPRITE_H, 4, sprite height in virtual pixels (1..FB_HEIGHT)
- STEP, 1, virtual pixels moved per accepted move
- FRAMES_PER_MOVE, 2, frame_tick pulses to wait after each draw (>=1)

Ports:
- clk, in, 1, system clock
- rst, in, 1, reset
- frame_tick, in, 1, one-cycle pulse per displayed frame
- move_right, in, 1, level, active-high, already debounced
- move_left, in, 1, level, active-high, already debounced
- move_up, in, 1, level, active-high, already debounced
- move_down, in, 1, level, active-high, already debounced
- fg_color, in, COLOR_W, sprite colour; sampled at each draw pixel
- bg_color, in, COLOR_W, background colour; sampled at each clear/erase pixel
- wr_addr, out, ADDR_W, framebuffer address = y*FB_WIDTH + x
- wr_data, out, COLOR_W, pixel data
- wr_en, out, 1, write strobe; one pixel per asserted cycle
- busy, out, 1, high in every state except WAIT
- pos_x, out, 10, sprite top-left x
- pos_y, out, 10, sprite top-left y

Behaviour:
- Interface: one clock; reset is asynchronous and active-high.
- Reset values:
  - wr_en=0, wr_addr=0, wr_data=0, busy=0, pos_x=0, pos_y=0.
  - Internal counters 0; state CLEAR_ALL entered on first clock after release.
- All outputs registered. wr_addr/wr_data/wr_en change together.
- States:
  - CLEAR_ALL: writes bg_color to addresses 0..FB_WIDTH*FB_HEIGHT-1 ascending, one per cycle, then -> DRAW.
  - WAIT: wr_en=0, busy=0.
    - Samples direction inputs.
    - dx = +STEP (right only), -STEP (left only), else 0. Right+left together gives 0.
    - dy = -STEP (up only), +STEP (down only), else 0. Up+down together gives 0.
    - If dx or dy is nonzero, latch them and go to ERASE; otherwise stay.
  - ERASE: writes bg_color over the SPRITE_W*SPRITE_H rectangle at the current position, row-major (x inner), then -> UPDATE.
  - UPDATE: one cycle, wr_en=0.
    - pos_x = clamp(pos_x+dx, 0, FB_WIDTH-SPRITE_W); pos_y = clamp(pos_y+dy, 0, FB_HEIGHT-SPRITE_H).
    - Arithmetic signed 12-bit; no wrap.
    - -> DRAW.
  - DRAW: writes fg_color over the rectangle at the new position, row-major, then -> HOLD.
  - HOLD: wr_en=0. Counts frame_tick pulses; after FRAMES_PER_MOVE pulses -> WAIT.
    - A frame_tick coinciding with HOLD entry counts.
- Timing:
  - Post-reset init is FB_WIDTH*FB_HEIGHT + SPRITE_W*SPRITE_H write cycles.
  - Move latency from WAIT detection to last draw write is 2*SPRITE_W*SPRITE_H + 2 cycles.
- Boundary cases:
  - A move clamped to zero displacement still performs ERASE/DRAW at the same position and still HOLDs.
  - Inputs are ignored outside WAIT; held inputs repeat at one move per HOLD period.
  - rst mid-operation aborts immediately; the next run re-clears the whole framebuffer.
- No write ever targets an address >= FB_WIDTH*FB_HEIGHT.

Optional Feature:
- Macro: SPRITE_WRAP_EN.
- When defined:
  - UPDATE computes pos_x = (pos_x+dx) mod FB_WIDTH and pos_y = (pos_y+dy) mod FB_HEIGHT, with no clamping.
  - ERASE/DRAW pixel coordinates are taken modulo FB_WIDTH/FB_HEIGHT, so the sprite straddles edges toroidally.
- When undefined: clamp behaviour as above, and the sprite never crosses an edge.

Test Plan:
- Reset release with defaults -> 19200 writes of bg_color at addresses 0..19199 ascending, then 16 writes of fg_color at 0,1,2,3,160,161,162,163,...,483; busy falls afterwards.
- move_right pulsed in WAIT, pos (0,0) -> erase 16 writes at (0..3,0..3), pos_x=1, draw addresses 1..4, 161..164, 321..324, 481..484; no return to WAIT until 2 frame_ticks.
- move_right+move_down held at (155,115) -> pos stays (156,116) after the first move, then repeats with unchanged position every HOLD; no address >=19200.
- move_left+move_right together, nothing else -> stays in WAIT, wr_en never asserted.
- rst asserted mid-DRAW -> outputs return to reset values the same cycle; after release, a full CLEAR_ALL is repeated.
- SPRITE_WRAP_EN, pos (0,0), move_left -> pos_x=159; draw writes x in {159,0,1,2} for each of rows 0..3.
